// File: rtl/loco_pkg.sv
// Shared constants and types for the LOCO-I context-quantisation path.
package loco_pkg;
  localparam int QG_W    = 4;
  localparam int CTX_W   = 9;
  localparam int CTX_NUM = 365;
  localparam int CTX_RUN = 0;

  typedef logic signed [QG_W-1:0] qg_t;
endpackage

// File: rtl/grad_quantizer.sv
// Combinational quantiser: one signed gradient against T1/T2/T3/NEAR -> -4..4.
module grad_quantizer
  import loco_pkg::*;
#(
  parameter int BPP = 8
) (
  input  logic signed [BPP:0]   i_d,
  input  logic        [BPP-1:0] i_t1,
  input  logic        [BPP-1:0] i_t2,
  input  logic        [BPP-1:0] i_t3,
  input  logic        [BPP-1:0] i_near,
  output logic signed [QG_W-1:0] o_q
);

  // One extra bit so negated 8-bit thresholds stay representable.
  logic signed [BPP+1:0] w_d;
  logic signed [BPP+1:0] w_t1;
  logic signed [BPP+1:0] w_t2;
  logic signed [BPP+1:0] w_t3;
  logic signed [BPP+1:0] w_near;

  assign w_d    = {i_d[BPP], i_d};
  assign w_t1   = {2'b00, i_t1};
  assign w_t2   = {2'b00, i_t2};
  assign w_t3   = {2'b00, i_t3};
  assign w_near = {2'b00, i_near};

  always_comb begin
    if (w_d <= -w_t3)        o_q = qg_t'(-4);
    else if (w_d <= -w_t2)   o_q = qg_t'(-3);
    else if (w_d <= -w_t1)   o_q = qg_t'(-2);
    else if (w_d < -w_near)  o_q = qg_t'(-1);
    else if (w_d <= w_near)  o_q = qg_t'(0);
    else if (w_d < w_t1)     o_q = qg_t'(1);
    else if (w_d < w_t2)     o_q = qg_t'(2);
    else if (w_d < w_t3)     o_q = qg_t'(3);
    else                     o_q = qg_t'(4);
  end

endmodule

// File: rtl/context_quant_pipe.sv
// Two-stage valid/ready pipeline: gradient quantisation, then sign
// normalisation and merge into a 0..364 context index.
module context_quant_pipe
  import loco_pkg::*;
#(
  parameter int BPP = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [BPP:0]  D1,
  input  logic signed [BPP:0]  D2,
  input  logic signed [BPP:0]  D3,
  input  logic [BPP-1:0]       Ix,
  input  logic [BPP-1:0]       Px,
  input  logic [BPP-1:0]       T1,
  input  logic [BPP-1:0]       T2,
  input  logic [BPP-1:0]       T3,
  input  logic [BPP-1:0]       NEAR,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTX_W-1:0]     Q,
  output logic                 sign,
  output logic                 run,
  output logic [BPP-1:0]       Ix_out,
  output logic [BPP-1:0]       Px_out
);

  localparam int EXT_W = CTX_W - QG_W;

  function automatic logic [CTX_W-1:0] ctx_index(qg_t a, qg_t b, qg_t c);
    logic signed [CTX_W-1:0] s;
    // Result is always 0..364, so modulo-512 arithmetic is exact.
    s = 9'sd81 * $signed({{EXT_W{a[QG_W-1]}}, a})
      + 9'sd9  * $signed({{EXT_W{b[QG_W-1]}}, b})
      +          $signed({{EXT_W{c[QG_W-1]}}, c});
    return s;
  endfunction

  function automatic qg_t cond_neg(qg_t v, logic neg);
    return neg ? -v : v;
  endfunction

  qg_t              w_q1, w_q2, w_q3;
  logic             r_s1_valid;
  qg_t              r_q1, r_q2, r_q3;
  logic [BPP-1:0]   r_ix1, r_px1;
  logic             r_out_valid;
  logic [CTX_W-1:0] r_q;
  logic             r_sign, r_run;
  logic [BPP-1:0]   r_ix, r_px;
  logic             w_s2_load, w_in_fire, w_neg, w_run;
  logic [CTX_W-1:0] w_ctx;

  grad_quantizer #(.BPP(BPP)) u_gq1 (
    .i_d(D1), .i_t1(T1), .i_t2(T2), .i_t3(T3), .i_near(NEAR), .o_q(w_q1));
  grad_quantizer #(.BPP(BPP)) u_gq2 (
    .i_d(D2), .i_t1(T1), .i_t2(T2), .i_t3(T3), .i_near(NEAR), .o_q(w_q2));
  grad_quantizer #(.BPP(BPP)) u_gq3 (
    .i_d(D3), .i_t1(T1), .i_t2(T2), .i_t3(T3), .i_near(NEAR), .o_q(w_q3));

  assign w_s2_load = r_s1_valid & (!r_out_valid | out_ready);
  assign in_ready  = !reset & (!r_s1_valid | w_s2_load);
  assign w_in_fire = in_valid & in_ready;

  // Stage 1 -> stage 2 boundary: quantised triple and sideband.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_q1  <= w_q1;
      r_q2  <= w_q2;
      r_q3  <= w_q3;
      r_ix1 <= Ix;
      r_px1 <= Px;
    end
  end

  assign w_run = (r_q1 == '0) & (r_q2 == '0) & (r_q3 == '0);
  assign w_neg = r_q1[QG_W-1]
               | ((r_q1 == '0) & r_q2[QG_W-1])
               | ((r_q1 == '0) & (r_q2 == '0) & r_q3[QG_W-1]);
  assign w_ctx = ctx_index(cond_neg(r_q1, w_neg), cond_neg(r_q2, w_neg),
                           cond_neg(r_q3, w_neg));

  // Stage 2 -> output boundary; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_sign      <= 1'b0;
      r_run       <= 1'b0;
      r_ix        <= '0;
      r_px        <= '0;
    end else begin
      r_s1_valid  <= w_in_fire | (r_s1_valid & !w_s2_load);
      r_out_valid <= w_s2_load | (r_out_valid & !out_ready);
      if (w_s2_load) begin
        r_q    <= w_run ? CTX_W'(CTX_RUN) : w_ctx;
        r_sign <= w_neg;
        r_run  <= w_run;
        r_ix   <= r_ix1;
        r_px   <= r_px1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign Q         = r_q;
  assign sign      = r_sign;
  assign run       = r_run;
  assign Ix_out    = r_ix;
  assign Px_out    = r_px;

endmodule

// File: tb/tb_context_quant_pipe.sv
// Bench for context_quant_pipe: directed vectors, random traffic,
// backpressure and mid-stream reset, checked against a queue of expectations.
module tb_context_quant_pipe;
  localparam int BPP = 8;

  typedef struct {
    int q;
    int sgn;
    int rn;
    int ix;
    int px;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [BPP:0] D1, D2, D3;
  logic [BPP-1:0]      Ix, Px, T1, T2, T3, NEAR;
  logic                out_valid;
  logic                out_ready;
  logic [8:0]          Q;
  logic                sign, run;
  logic [BPP-1:0]      Ix_out, Px_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   use_const = 1'b0;
  exp_t const_exp;
  bit   last_stall = 1'b0;
  exp_t held;

  always #5 clk = ~clk;

  context_quant_pipe #(.BPP(BPP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .D1(D1), .D2(D2), .D3(D3), .Ix(Ix), .Px(Px),
    .T1(T1), .T2(T2), .T3(T3), .NEAR(NEAR),
    .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .sign(sign), .run(run),
    .Ix_out(Ix_out), .Px_out(Px_out));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int quant(int d);
    int t1 = int'(T1), t2 = int'(T2), t3 = int'(T3), nr = int'(NEAR);
    if (d <= -t3) return -4;
    if (d <= -t2) return -3;
    if (d <= -t1) return -2;
    if (d < -nr)  return -1;
    if (d <= nr)  return 0;
    if (d < t1)   return 1;
    if (d < t2)   return 2;
    if (d < t3)   return 3;
    return 4;
  endfunction

  function automatic exp_t model(int d1, int d2, int d3, int ix, int px);
    exp_t e;
    int a = quant(d1), b = quant(d2), c = quant(d3);
    bit neg = (a < 0) || (a == 0 && b < 0) || (a == 0 && b == 0 && c < 0);
    if (neg) begin a = -a; b = -b; c = -c; end
    e.q   = 81 * a + 9 * b + c;
    e.sgn = neg ? 1 : 0;
    e.rn  = (a == 0 && b == 0 && c == 0) ? 1 : 0;
    e.ix  = ix;
    e.px  = px;
    return e;
  endfunction

  // Monitor: looks at the handshake just before each rising edge.
  always @(negedge clk) begin
    exp_t e;
    chk("in_ready", in_ready, (!reset && (sb.size() < 2 || out_ready)) ? 1 : 0);
    if (last_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_Q", Q, held.q);
      chk("stall_sign", sign, held.sgn);
      chk("stall_Ix", Ix_out, held.ix);
    end
    if (reset) begin
      sb.delete();
      last_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("stale_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("Q", Q, e.q);
          chk("sign", sign, e.sgn);
          chk("run", run, e.rn);
          chk("Ix_out", Ix_out, e.ix);
          chk("Px_out", Px_out, e.px);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(use_const ? const_exp :
                     model(int'(D1), int'(D2), int'(D3), int'(Ix), int'(Px)));
      last_stall = out_valid && !out_ready;
      held.q = int'(Q); held.sgn = int'(sign); held.ix = int'(Ix_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(int d1, int d2, int d3, int ix, int px);
    D1 = 9'(d1); D2 = 9'(d2); D3 = 9'(d3); Ix = 8'(ix); Px = 8'(px);
  endtask

  task automatic send_const(int d1, int d2, int d3, int ix, int px,
                            int q, int sg, int rn);
    set_d(d1, d2, d3, ix, px);
    const_exp.q = q; const_exp.sgn = sg; const_exp.rn = rn;
    const_exp.ix = ix; const_exp.px = px;
    use_const = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("tput_ready", in_ready, 1);
    tick();
    in_valid  = 1'b0;
    use_const = 1'b0;
  endtask

  initial begin
    int sent;
    bit acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    T1 = 8'd3; T2 = 8'd7; T3 = 8'd21; NEAR = 8'd0;
    set_d(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_Q", Q, 0);
    chk("rst_run", run, 0);
    chk("rst_Ix", Ix_out, 0);
    chk("rst_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Latency and run-mode beat.
    send_const(0, 0, 0, 17, 16, 0, 0, 1);
    chk("lat_early", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_run", run, 1);
    chk("lat_Ix", Ix_out, 17);
    chk("lat_Px", Px_out, 16);

    // Back-to-back directed vectors.
    in_valid = 1'b1;
    send_const(5, -2, 25, 1, 2, 157, 0, 0);
    send_const(-8, 3, 0, 3, 4, 225, 1, 0);
    send_const(-256, 0, 0, 5, 6, 324, 1, 0);
    send_const(0, 0, 255, 7, 8, 4, 0, 0);
    repeat (4) tick();
    chk("directed_drain", sb.size(), 0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 200; c++) begin
      set_d(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
            int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("random_drain", sb.size(), 0);

    // Five beats with out_ready low for cycles 3..6.
    sent = 0;
    for (int c = 0; c < 40 && (sent < 5 || sb.size() > 0); c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 5);
      set_d(sent * 4 - 9, 10 - sent * 5, sent, 40 + sent, 80 + sent);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 5) begin
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_valid", out_valid, 1);
      end
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", sent, 5);
    chk("bp_drain", sb.size(), 0);

    // Fill both stages, then reset for one cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_d(-30, 12, 4, 99, 98);
    for (int c = 0; c < 10 && sb.size() < 2; c++) tick();
    chk("mid_full", sb.size(), 2);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_Q", Q, 0);
    chk("mid_rst_sign", sign, 0);
    chk("mid_rst_run", run, 0);
    chk("mid_rst_Ix", Ix_out, 0);
    chk("mid_rst_Px", Px_out, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("no_stale", out_valid, 0);
    end

    // One beat after reset still flows normally.
    send_const(-8, 3, 0, 11, 12, 225, 1, 0);
    repeat (3) tick();
    chk("final_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/context_quant_pipe.md
# context_quant_pipe

Parametrised, flow-controlled successor to the LOCO-I/JPEG-LS context-quantisation stage. Takes the three local gradients D1..D3 with the current pixel Ix and prediction Px. Quantises each gradient against runtime thresholds (T1, T2, T3, NEAR) and sign-normalises the triple. Emits the merged context index Q, the sign flag and a run-mode flag, with Ix/Px carried alongside. Sits between gradient computation and the context-statistics/prediction-correction stage, and adds valid/ready backpressure in place of a free-running enable.

## Interface
- BPP, 8: sample bit depth; gradients are BPP+1 bits signed.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts beat this cycle.
- D1, D2, D3  in  BPP+1  signed gradients.
- Ix, Px  in  BPP  pixel and prediction sideband.
- T1, T2, T3  in  BPP  unsigned thresholds; static while any beat is in flight.
- NEAR  in  BPP  near-lossless bound; 0 for lossless.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts beat.
- Q  out  9  context index, 0..364.
- sign  out  1  1 when the triple was negated.
- run  out  1  1 when all quantised gradients are 0.
- Ix_out, Px_out  out  BPP  sideband aligned with Q.

## Operation
- Stage 1 quantises each Di to qi in -4..4, tested in this order, first match wins:
  - Di <= -T3 → -4; Di <= -T2 → -3; Di <= -T1 → -2; Di < -NEAR → -1.
  - Di <= NEAR → 0; Di < T1 → 1; Di < T2 → 2; Di < T3 → 3; else 4.
- All compares are signed at BPP+2 bits. Thresholds and NEAR are zero-extended.
- Caller guarantees NEAR < T1 <= T2 <= T3. Outside that ordering the first-match order above still defines the result.
- Stage 2 merges the triple:
  - Sign: if the first non-zero of (q1, q2, q3) is negative, negate all three and set sign=1; else sign=0.
  - Index: Q = 81*q1 + 9*q2 + q3 on the normalised values. This is unique and lies in 0..364.
  - Run: run=1 exactly when q1=q2=q3=0; then Q=0 and sign=0.
- Ix/Px travel unmodified through both stages with their beat.
- Handshake:
  - A beat transfers on in_valid&in_ready, and on out_valid&out_ready.
  - Each stage holds a valid bit. A stage loads when it is empty, or when its contents move on in the same cycle.
  - in_ready = !s1_valid | (s1 advances this cycle). It is 0 while reset is high.
  - Output registers and out_valid stay stable while out_valid&!out_ready.
  - No beat is lost, duplicated or reordered.
- Data outputs hold the last beat when out_valid=0. They are checked only under out_valid.

## Timing
- Latency: 2 cycles from input acceptance to out_valid, with no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Capacity: 2 beats. With out_ready held low, in_ready drops after the second accepted beat. It rises in the same cycle that out_ready returns high (pass-through).
- Reset: next edge clears both valid bits and sets out_valid=0, Q=0, sign=0, run=0, Ix_out=0, Px_out=0.
  - In-flight beats are discarded.
  - in_ready=1 on the first cycle after reset deasserts.
- Simultaneous accept and emit with both stages full: the beats shift by one and occupancy stays at 2.
- Threshold or NEAR change while beats are in flight: result undefined. The bench must not do this.

## Structure
- Shared package loco_pkg holds:
  - constants QG_W=4, CTX_W=9, CTX_NUM=365, CTX_RUN=0;
  - a typedef for the signed quantised-gradient value.
- Sub-module grad_quantizer: combinational, one gradient plus thresholds → qi. Instantiated three times in stage 1.
- The two pipeline stages, sign normalisation and handshake logic live in the top module.

## Test plan
Settings for all scenarios: BPP=8, T1=3, T2=7, T3=21, NEAR=0.
- D=(0,0,0), Ix=17, Px=16 → 2 cycles later: run=1, Q=0, sign=0, Ix_out=17, Px_out=16.
- D=(5,-2,25) → q=(2,-1,4): Q=157, sign=0, run=0.
- D=(-8,3,0) → q=(-3,2,0), normalised (3,-2,0): Q=225, sign=1.
- Extremes D=(-256,0,0) and D=(0,0,255) → Q=324 with sign=1, then Q=4 with sign=0.
- Backpressure:
  - Stimulus: stream 5 beats with in_valid=1; out_ready low for cycles 3-6, then high.
  - Response: in_ready=0 after 2 beats are held; outputs stay stable while stalled; all 5 beats appear in order, each once.
- Reset mid-stream:
  - Stimulus: both stages full, then reset pulsed 1 cycle.
  - Response: out_valid=0 and all outputs 0 the next cycle; in_ready=1 after release; no stale beat emerges.
